bcast_fanout_sched: RTL

Per-router scheduler that turns one incoming short-broadcast flit into one outgoing flit per communicator child. Child addresses and child count come from a locally held, software-writable communicator table. It sits between the collective-instruction stage and the router injection port. It sequences copies under output backpressure and passes non-broadcast flits through unchanged.

---
 rtl/bcast_fanout_sched_if.sv | 24 ++
 rtl/bcast_fanout_sched.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcast_fanout_sched_if.sv
// Flit handshake between the collective stage, the fanout scheduler and the router injection port.
// The slave modport is the scheduler's view; the master modport is the view of whatever drives and sinks it.
interface bcast_fanout_sched_if #(
  parameter int FlitWidth = 73
);
  logic [FlitWidth-1:0] packetIn;
  logic                 in_ready;
  logic [FlitWidth-1:0] packetOut;
  logic                 out_ready;

  modport slave (
    input  packetIn,
    output in_ready,
    output packetOut,
    input  out_ready
  );

  modport master (
    output packetIn,
    input  in_ready,
    input  packetOut,
    output out_ready
  );
endinterface

// File: rtl/bcast_fanout_sched.sv
// Fans one short-broadcast flit out to each communicator child; other flits pass through as a single copy.
// First copy is registered one cycle after accept; packetOut holds while out_ready is low, and no new flit is taken until all copies drain.
module bcast_fanout_sched #(
  parameter int         FlitWidth      = 73,
  parameter int         DstWidth       = 9,
  parameter int         CommTableWidth = 43,
  parameter int         CommTableSize  = 4,
  parameter int         AddrWidth      = $clog2(CommTableSize),
  parameter logic [3:0] BcastOp        = 4'b1111
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [AddrWidth-1:0]      cfg_addr,
  input  logic [CommTableWidth-1:0] cfg_data,
  bcast_fanout_sched_if.slave       fl,
  output logic                      busy,
  output logic                      err_ctx,
  output logic [15:0]               sent_cnt
);

  localparam int VldBit = 72;
  localparam int DstHi  = 71;
  localparam int DstLo  = 63;
  localparam int CtxHi  = 53;
  localparam int CtxLo  = 46;
  localparam int OpHi   = 35;
  localparam int OpLo   = 32;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;

  logic [CommTableWidth-1:0] comm_tbl [CommTableSize];

  logic [1:0]          idx_q, cnt_q;
  logic [DstWidth-1:0] dst0_q, dst1_q, dst2_q;
  logic [DstLo-1:0]    rest_q;
  logic [FlitWidth-1:0] pkt_q;
  logic [15:0]         sent_q;
  logic                err_q;

  // Decode of the incoming flit and its communicator entry
  logic [7:0]                in_ctx;
  logic [3:0]                in_op;
  logic [DstWidth-1:0]       in_dst;
  logic [CommTableWidth-1:0] entry;
  logic [2:0]                in_children;
  logic [DstWidth-1:0]       slot0, slot1, slot2;
  logic [12:0]               unused_entry_bits;
  logic                      ctx_ok, is_bcast, accept, go_send, fire, last;
  logic [1:0]                in_cnt;

  assign in_ctx   = fl.packetIn[CtxHi:CtxLo];
  assign in_op    = fl.packetIn[OpHi:OpLo];
  assign in_dst   = fl.packetIn[DstHi:DstLo];
  assign ctx_ok   = in_ctx < 8'(CommTableSize);
  assign is_bcast = in_op == BcastOp;

  assign entry             = comm_tbl[in_ctx[AddrWidth-1:0]];
  assign in_children       = entry[33:31];
  assign slot2             = entry[26:18];
  assign slot1             = entry[17:9];
  assign slot0             = entry[8:0];
  // local_rank and lg_commsize are held for software but not needed for fanout
  assign unused_entry_bits = {entry[42:34], entry[30:27]};

  always_comb begin
    in_cnt = 2'd1;
    if (is_bcast) begin
      in_cnt = (in_children > 3'd3) ? 2'd3 : in_children[1:0];
    end
  end

  assign accept  = fl.packetIn[VldBit] & fl.in_ready;
  assign go_send = accept & ctx_ok & (in_cnt != 2'd0);
  assign fire    = (state_q == SEND) & fl.out_ready;
  assign last    = idx_q == (cnt_q - 2'd1);

  // Communicator table; a same-cycle write is seen only by the following accept
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CommTableSize; i++) begin
        comm_tbl[i] <= '0;
      end
    end else if (cfg_we) begin
      comm_tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_send) state_d = SEND;
      SEND:    if (fire && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fl.in_ready = (state_q == IDLE) & ~rst;
    busy        = state_q == SEND;
  end

  // Copy sequencing: slots are snapshotted at accept so later table writes cannot leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      dst0_q <= '0;
      dst1_q <= '0;
      dst2_q <= '0;
      rest_q <= '0;
      pkt_q  <= '0;
      sent_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & ~ctx_ok;
      if (go_send) begin
        idx_q  <= '0;
        cnt_q  <= in_cnt;
        dst0_q <= is_bcast ? slot0 : in_dst;
        dst1_q <= slot1;
        dst2_q <= slot2;
        rest_q <= fl.packetIn[DstLo-1:0];
        pkt_q  <= {1'b1, (is_bcast ? slot0 : in_dst), fl.packetIn[DstLo-1:0]};
      end else if (fire) begin
        sent_q <= sent_q + 16'd1;
        if (last) begin
          idx_q         <= '0;
          pkt_q[VldBit] <= 1'b0;
        end else begin
          idx_q <= idx_q + 2'd1;
          pkt_q <= {1'b1, ((idx_q == 2'd0) ? dst1_q : dst2_q), rest_q};
        end
      end
    end
  end

  assign fl.packetOut = pkt_q;
  assign err_ctx      = err_q;
  assign sent_cnt     = sent_q;

endmodule
